// File: rtl/wide_mux_2x1.sv
// wide_mux_2x1: shared-select 1-bit and WIDTH-bit 2:1 muxes with combinational and registered outputs
module wide_mux_2x1 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             a,
    input  logic             b,
    output logic             q,
    input  logic [WIDTH-1:0] wa,
    input  logic [WIDTH-1:0] wb,
    output logic [WIDTH-1:0] wq,
    output logic             q_r,
    output logic [WIDTH-1:0] wq_r
);
    logic [WIDTH-1:0] sel_w;
    logic             narrow_d, narrow_q;
    logic [WIDTH-1:0] wide_d, wide_q;

    // AND-OR select; the a&b consensus term keeps agreeing bits steady across a sel change or an unknown sel
    always_comb begin
        sel_w    = {WIDTH{sel}};
        narrow_d = (a & ~sel) | (b & sel) | (a & b);
        wide_d   = (wa & ~sel_w) | (wb & sel_w) | (wa & wb);
    end

    // Pipeline-boundary copies, captured every cycle and cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            narrow_q <= 1'b0;
            wide_q   <= '0;
        end else begin
            narrow_q <= narrow_d;
            wide_q   <= wide_d;
        end
    end

    assign q    = narrow_d;
    assign wq   = wide_d;
    assign q_r  = narrow_q;
    assign wq_r = wide_q;
endmodule

// File: tb/tb_wide_mux_2x1.sv
// tb_wide_mux_2x1: directed and randomized checks of wide_mux_2x1 at WIDTH 32, 1 and 64
module tb_wide_mux_2x1;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        a = 1'b0;
    logic        b = 1'b0;
    logic        q32, q1, q64, qr32, qr1, qr64;
    logic [31:0] wa32 = '0, wb32 = '0, wq32, wqr32;
    logic [0:0]  wa1 = '0, wb1 = '0, wq1, wqr1;
    logic [63:0] wa64 = '0, wb64 = '0, wq64, wqr64;
    logic [31:0] w_s0;
    logic [0:0]  e1;
    logic [63:0] e64;
    logic        eq;
    int          n_cmp = 0;
    int          n_err = 0;

    wide_mux_2x1 #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .sel(sel), .a(a), .b(b), .q(q32),
        .wa(wa32), .wb(wb32), .wq(wq32), .q_r(qr32), .wq_r(wqr32));
    wide_mux_2x1 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .sel(sel), .a(a), .b(b), .q(q1),
        .wa(wa1), .wb(wb1), .wq(wq1), .q_r(qr1), .wq_r(wqr1));
    wide_mux_2x1 #(.WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .sel(sel), .a(a), .b(b), .q(q64),
        .wa(wa64), .wb(wb64), .wq(wq64), .q_r(qr64), .wq_r(wqr64));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        a = 1'b1; b = 1'b0; sel = 1'b0; wa32 = 32'h1234_5678; wb32 = 32'h9ABC_DEF0;
        #2;
        chk("reset_q_r", qr32, 0);
        chk("reset_wq_r", wqr32, 0);
        chk("reset_wq_r64", wqr64, 0);
        chk("reset_q_live", q32, 1);
        chk("reset_wq_live", wq32, 32'h1234_5678);
        @(posedge clk); #1;
        chk("reset_hold_wq_r", wqr32, 0);
        @(negedge clk); rst_n = 1'b1;
        // narrow lane, no clock needed
        sel = 1'b0; a = 1'b1; b = 1'b0; #1 chk("narrow_selA_1", q32, 1);
        a = 1'b0; #1 chk("narrow_selA_0", q32, 0);
        sel = 1'b1; a = 1'b0; b = 1'b1; #1 chk("narrow_selB_1", q32, 1);
        b = 1'b0; #1 chk("narrow_selB_0", q32, 0);
        // wide lane
        wa32 = 32'hDEAD_BEEF; wb32 = 32'hCAFE_BABE; sel = 1'b0;
        #1 chk("wide_selA", wq32, 32'hDEAD_BEEF);
        w_s0 = wq32;
        sel = 1'b1;
        #1 chk("wide_selB", wq32, 32'hCAFE_BABE);
        chk("wide_agree_steady", (w_s0 ^ wq32) & ~(wa32 ^ wb32), 0);
        // registered path
        @(negedge clk); sel = 1'b0; a = 1'b0; b = 1'b1;
        @(posedge clk); #1;
        chk("reg_N_wq_r", wqr32, 32'hDEAD_BEEF);
        chk("reg_N_q_r", qr32, 0);
        sel = 1'b1;
        #1 chk("reg_hold_wq_r", wqr32, 32'hDEAD_BEEF);
        chk("reg_hold_q_r", qr32, 0);
        chk("reg_live_wq", wq32, 32'hCAFE_BABE);
        @(posedge clk); #1;
        chk("reg_N1_wq_r", wqr32, 32'hCAFE_BABE);
        chk("reg_N1_q_r", qr32, 1);
        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1 chk("async_wq_r", wqr32, 0);
        chk("async_q_r", qr32, 0);
        chk("async_live_q", q32, 1);
        chk("async_live_wq", wq32, 32'hCAFE_BABE);
        sel = 1'b0;
        #1 chk("async_live_wq_sel0", wq32, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("async_edge_wq_r", wqr32, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_wq_r", wqr32, 32'hDEAD_BEEF);
        chk("release_q_r", qr32, 0);
        // randomized width checks
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            sel  = 1'($urandom_range(0, 1));
            a    = 1'($urandom_range(0, 1));
            b    = 1'($urandom_range(0, 1));
            wa1  = 1'($urandom_range(0, 1));
            wb1  = 1'($urandom_range(0, 1));
            wa64 = {$urandom, $urandom};
            wb64 = {$urandom, $urandom};
            e1   = sel ? wb1 : wa1;
            e64  = sel ? wb64 : wa64;
            eq   = sel ? b : a;
            #1;
            chk("w1_wq", wq1, e1);
            chk("w64_wq", wq64, e64);
            chk("w64_q", q64, eq);
            @(posedge clk); #1;
            chk("w1_wq_r", wqr1, e1);
            chk("w64_wq_r", wqr64, e64);
            chk("w1_q_r", qr1, eq);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
